// File: rtl/key_event_if.sv
// Key event bus between the key event controller and its consumers.
// The master drives the debounced key level; the slave returns the events and the effect mode.
interface key_event_if #(
   parameter int NUM_MODES = 4
);
   localparam int MODE_W = $clog2(NUM_MODES);

   logic              key_in;
   logic              press_pulse;
   logic              release_pulse;
   logic              long_pulse;
   logic              repeat_pulse;
   logic [MODE_W-1:0] mode;
   logic              mode_changed;

   modport master (
      output key_in,
      input  press_pulse, release_pulse, long_pulse, repeat_pulse, mode, mode_changed
   );

   modport slave (
      input  key_in,
      output press_pulse, release_pulse, long_pulse, repeat_pulse, mode, mode_changed
   );
endinterface

// File: rtl/key_event_ctrl.sv
// Turns the debounced key level into press/release/long/repeat pulses and a wrapping effect mode.
// Auto-repeat pulses in HOLD are compiled in only when KEY_AUTOREPEAT_EN is defined.
module key_event_ctrl #(
   parameter int NUM_MODES  = 4,
   parameter int LONG_CYC   = 25_000_000,
   parameter int REPEAT_CYC = 5_000_000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic        clk,
   input logic        rst,
   key_event_if.slave kif
);
   localparam int MODE_W  = $clog2(NUM_MODES);
   localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
   localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

   typedef enum logic [1:0] {
      WAIT_REL,
      IDLE,
      PRESS,
      HOLD
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [MODE_W-1:0] mode_q;
   logic              press_q;
   logic              release_q;
   logic              long_q;
   logic              repeat_q;
   logic              changed_q;
   logic              pressed;

   assign pressed = kif.key_in ^ ACTIVE_LOW;

   // The hold counter saturates instead of wrapping.
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT_REL;
         cnt       <= '0;
         mode_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         changed_q <= 1'b0;

         unique case (state)
            // A key held through reset must be released before any press counts.
            WAIT_REL: begin
               if (!pressed) begin
                  state <= IDLE;
               end
            end

            IDLE: begin
               if (pressed) begin
                  press_q <= 1'b1;
                  cnt     <= '0;
                  state   <= PRESS;
               end
            end

            // Release is checked first so a release on the threshold edge stays a short press.
            PRESS: begin
               if (!pressed) begin
                  release_q <= 1'b1;
                  mode_q    <= (mode_q == LAST_MODE) ? '0 : mode_q + MODE_W'(1);
                  changed_q <= 1'b1;
                  state     <= IDLE;
               end else if (cnt == LONG_LAST) begin
                  long_q    <= 1'b1;
                  cnt       <= '0;
                  changed_q <= (mode_q != '0);
                  mode_q    <= '0;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            HOLD: begin
               if (!pressed) begin
                  release_q <= 1'b1;
                  state     <= IDLE;
               end else begin
`ifdef KEY_AUTOREPEAT_EN
                  if (cnt == REP_LAST) begin
                     repeat_q <= 1'b1;
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
`else
                  cnt <= cnt;
`endif
               end
            end

            default: begin
               state <= WAIT_REL;
            end
         endcase
      end
   end

   assign kif.press_pulse   = press_q;
   assign kif.release_pulse = release_q;
   assign kif.long_pulse    = long_q;
   assign kif.repeat_pulse  = repeat_q;
   assign kif.mode          = mode_q;
   assign kif.mode_changed  = changed_q;
endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Converts the debounced push-button level from the debouncer stage into single-cycle key events and a wrapping effect-mode selector for the audio processing path. It sits directly downstream of the debouncer and upstream of the effect multiplexer. A short press advances the mode, a long press returns it to mode 0, and optional auto-repeat pulses fire while the key is held.

## Interface
- `NUM_MODES`, 4: number of effect modes, at least 2; `mode` wraps at `NUM_MODES-1`.
- `LONG_CYC`, 25_000_000: hold cycles before a long press is declared, at least 2.
- `REPEAT_CYC`, 5_000_000: cycles between auto-repeat pulses, at least 2.
- `ACTIVE_LOW`, 1: 1 means `key_in`=0 is pressed (DE2-115 KEY polarity).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in 1: debounced key level from the debouncer.
- `press_pulse` out 1: one-cycle pulse on the press edge.
- `release_pulse` out 1: one-cycle pulse on the release edge.
- `long_pulse` out 1: one-cycle pulse when the hold reaches `LONG_CYC`.
- `repeat_pulse` out 1: one-cycle pulse every `REPEAT_CYC` while in HOLD (macro-dependent).
- `mode` out `$clog2(NUM_MODES)`: current effect mode.
- `mode_changed` out 1: one-cycle pulse in the cycle `mode` takes a new value.

## Operation
- `pressed` = `key_in ^ ACTIVE_LOW`, evaluated combinationally.
- Hold counter width is `$clog2(max(LONG_CYC, REPEAT_CYC))+1` and it saturates, so it never wraps.
- Reset values: state WAIT_REL, counter 0, `mode` 0, all pulse outputs 0.
- FSM states and transitions:
  - WAIT_REL: wait for `!pressed`, then go to IDLE. No pulses are emitted. This prevents a spurious press when the key is held through reset.
  - IDLE: on `pressed`, assert `press_pulse`, clear the counter, go to PRESS.
  - PRESS: counter increments each cycle.
    - On `!pressed` before the long threshold: assert `release_pulse`, set `mode` to (`mode==NUM_MODES-1`) ? 0 : `mode+1`, assert `mode_changed`, go to IDLE.
    - On counter reaching `LONG_CYC-1` while still pressed: assert `long_pulse`, clear the counter, go to HOLD.
    - In the long-press cycle, `mode` is set to 0. `mode_changed` is asserted only if `mode` was nonzero.
  - HOLD:
    - On `!pressed`: assert `release_pulse`, go to IDLE. `mode` is unchanged.
    - Otherwise the counter increments. At `REPEAT_CYC-1`, assert `repeat_pulse` (if enabled) and clear the counter.
- Release in the same cycle the long threshold would be hit: release wins. It is treated as a short press and `long_pulse` is not asserted.
- `rst` overrides everything in the same edge, including mid-press and mid-hold. Any pending pulse is dropped.
- At most one of `press_pulse`, `release_pulse`, `long_pulse`, `repeat_pulse` is high in any cycle.

## Timing
- All outputs are registered.
- If `key_in` changes before rising edge k, the corresponding pulse is high for exactly the cycle after edge k. Latency is 1 cycle.
- `mode` updates on the same edge as `release_pulse` (short press) or `long_pulse` (long press). `mode_changed` is coincident with that update.
- Long press: `long_pulse` follows `press_pulse` by exactly `LONG_CYC` cycles.
- Auto-repeat: first `repeat_pulse` follows `long_pulse` by `REPEAT_CYC` cycles, then repeats every `REPEAT_CYC` cycles.
- Minimum spacing between `press_pulse` and `release_pulse` is 1 cycle. A 1-cycle press is legal and counts as a short press.
- After `rst` deasserts with the key released: WAIT_REL exits in 1 cycle, and a press is accepted from the following cycle.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: HOLD generates `repeat_pulse` as described, and the repeat counter logic is compiled in.
- `KEY_AUTOREPEAT_EN` undefined:
  - `repeat_pulse` is tied to 0.
  - HOLD only waits for release, and the counter holds its value.
  - All other behaviour and timing are identical.

## Test plan
Bench parameters: `NUM_MODES`=3, `LONG_CYC`=8, `REPEAT_CYC`=4, `ACTIVE_LOW`=1, macro defined unless noted.
- Short press: `key_in` low for 3 cycles, then high. Expect `press_pulse` at cycle 1, `release_pulse` 3 cycles later, `mode` 0→1 with `mode_changed`.
- Wrap-around: three short presses from reset. Expect `mode` sequence 1, 2, 0, with `mode_changed` on each press.
- Long press with repeat: from `mode`=2, hold the key 20 cycles. Expect:
  - `long_pulse` 8 cycles after `press_pulse`, with `mode`→0 and `mode_changed`.
  - `repeat_pulse` at +4 and +8 after `long_pulse`.
  - `release_pulse` on release, with `mode` staying 0.
- Macro undefined, same stimulus: `repeat_pulse` never asserts; all other outputs match.
- Held through reset: `key_in`=0 with `rst` pulsed high for 2 cycles. Expect:
  - No `press_pulse` until `key_in` goes high and then low again.
  - `mode`=0 and all pulses 0 during and after reset.
- Release at threshold: release exactly at the 8th hold cycle. Expect `release_pulse` only, no `long_pulse`, and `mode` incremented.
